// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the regfile writeback arbiter.
package regfile_wb_arbiter_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_REG_W  = 5;

    // Round-robin priority pointer: which requester wins a simultaneous request.
    typedef enum logic {
        PRIO_ALU = 1'b0,
        PRIO_MD  = 1'b1
    } prio_e;

    // Bit positions of each requester in the request/grant vectors.
    localparam int REQ_ALU = 0;
    localparam int REQ_MD  = 1;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter with its priority register.
module rr_arbiter2
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       ctrl_reset,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    prio_e prio_q;
    prio_e prio_d;

    // Grant one requester; after a grant, priority moves to the loser.
    always_comb begin
        gnt    = 2'b00;
        prio_d = prio_q;
        if (ctrl_reset) begin
            prio_d = PRIO_ALU;
        end else begin
            if (req[REQ_ALU] && req[REQ_MD]) begin
                if (prio_q == PRIO_ALU) begin
                    gnt[REQ_ALU] = 1'b1;
                end else begin
                    gnt[REQ_MD] = 1'b1;
                end
            end else begin
                gnt = req;
            end
            if (gnt[REQ_ALU]) begin
                prio_d = PRIO_MD;
            end else if (gnt[REQ_MD]) begin
                prio_d = PRIO_ALU;
            end
        end
    end

    // Priority pointer register, ALU favoured out of reset.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            prio_q <= PRIO_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between the ALU and multdiv writeback paths.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W  = WB_DATA_W,
    parameter int REG_W   = WB_REG_W,
    parameter int DROP_R0 = 1
) (
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              alu_valid,
    input  logic [REG_W-1:0]  alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              md_valid,
    input  logic [REG_W-1:0]  md_reg,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    output logic              ctrl_writeEnable,
    output logic [REG_W-1:0]  ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    output logic              byp_valid,
    output logic [REG_W-1:0]  byp_reg,
    output logic [DATA_W-1:0] byp_data,
    output logic [15:0]       conflict_cnt
);

    logic [1:0]        gnt;
    logic [1:0]        req;
    logic              grant_any;
    logic [REG_W-1:0]  sel_reg;
    logic [DATA_W-1:0] sel_data;

    logic              write_en_q;
    logic              write_en_d;
    logic [REG_W-1:0]  write_reg_q;
    logic [REG_W-1:0]  write_reg_d;
    logic [DATA_W-1:0] write_data_q;
    logic [DATA_W-1:0] write_data_d;
    logic [15:0]       conflict_cnt_q;
    logic [15:0]       conflict_cnt_d;

    assign req[REQ_ALU] = alu_valid;
    assign req[REQ_MD]  = md_valid;

    rr_arbiter2 u_arb (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .req        (req),
        .gnt        (gnt)
    );

    // Select the winning write and compute the next output register and counter.
    always_comb begin
        grant_any    = gnt[REQ_ALU] | gnt[REQ_MD];
        sel_reg      = gnt[REQ_MD] ? md_reg : alu_reg;
        sel_data     = gnt[REQ_MD] ? md_data : alu_data;
        write_en_d   = grant_any && !((DROP_R0 != 0) && (sel_reg == '0));
        write_reg_d  = grant_any ? sel_reg : write_reg_q;
        write_data_d = grant_any ? sel_data : write_data_q;
        conflict_cnt_d = conflict_cnt_q;
        if (alu_valid && md_valid && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    // Output write register and conflict counter.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            write_en_q     <= 1'b0;
            write_reg_q    <= '0;
            write_data_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            write_en_q     <= write_en_d;
            write_reg_q    <= write_reg_d;
            write_data_q   <= write_data_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    // Reset kills a write already latched so it never commits during reset.
    always_comb begin
        alu_ready        = gnt[REQ_ALU];
        md_ready         = gnt[REQ_MD];
        ctrl_writeEnable = write_en_q && !ctrl_reset;
        ctrl_writeReg    = write_reg_q;
        data_writeReg    = write_data_q;
        byp_valid        = ctrl_writeEnable;
        byp_reg          = write_reg_q;
        byp_data         = write_data_q;
        conflict_cnt     = conflict_cnt_q;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for the regfile writeback arbiter.
module tb_regfile_wb_arbiter;

   logic        clock;
   logic        ctrl_reset;
   logic        alu_valid;
   logic [4:0]  alu_reg;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic        md_valid;
   logic [4:0]  md_reg;
   logic [31:0] md_data;
   logic        md_ready;
   logic        ctrl_writeEnable;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_writeReg;
   logic        byp_valid;
   logic [4:0]  byp_reg;
   logic [31:0] byp_data;
   logic [15:0] conflict_cnt;

   typedef struct {
      logic [4:0]  r;
      logic [31:0] d;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [31:0] rf [32];

   regfile_wb_arbiter dut (
      .clock            (clock),
      .ctrl_reset       (ctrl_reset),
      .alu_valid        (alu_valid),
      .alu_reg          (alu_reg),
      .alu_data         (alu_data),
      .alu_ready        (alu_ready),
      .md_valid         (md_valid),
      .md_reg           (md_reg),
      .md_data          (md_data),
      .md_ready         (md_ready),
      .ctrl_writeEnable (ctrl_writeEnable),
      .ctrl_writeReg    (ctrl_writeReg),
      .data_writeReg    (data_writeReg),
      .byp_valid        (byp_valid),
      .byp_reg          (byp_reg),
      .byp_data         (byp_data),
      .conflict_cnt     (conflict_cnt)
   );

   // Free-running clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Cycle counter and a behavioural regfile fed by the write port.
   initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
   always @(posedge clock) begin
      cyc++;
      if (ctrl_writeEnable) rf[ctrl_writeReg] = data_writeReg;
   end

   // Absolute time limit so the bench never hangs.
   initial begin
      #200000;
      $display("[TB] FAIL timeout");
      $fatal(1);
   end

   // Monitor: every regfile write must match the next expected write in its cycle.
   always @(negedge clock) begin
      exp_t e;
      if (ctrl_writeEnable) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("[TB] FAIL unexpected_write cyc=%0d reg=%0d data=%h, required no write", cyc, ctrl_writeReg, data_writeReg);
         end else begin
            e = sb.pop_front();
            if (ctrl_writeReg !== e.r || data_writeReg !== e.d || cyc != e.cyc ||
                byp_valid !== 1'b1 || byp_reg !== e.r || byp_data !== e.d) begin
               fails++;
               $display("[TB] FAIL write cyc=%0d reg=%0d data=%h byp=%b/%0d/%h, required cyc=%0d reg=%0d data=%h",
                        cyc, ctrl_writeReg, data_writeReg, byp_valid, byp_reg, byp_data, e.cyc, e.r, e.d);
            end
         end
      end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
         tests++;
         fails++;
         e = sb.pop_front();
         $display("[TB] FAIL missing_write cyc=%0d, required reg=%0d data=%h in cyc=%0d", cyc, e.r, e.d, e.cyc);
      end
   end

   // Compare one value against its hand-computed expectation.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s got=%h required=%h", name, act, exp);
      end
   endtask

   // Drive one cycle, check ready mid-cycle, and queue the write it should produce.
   task automatic applyStimulus(input logic rst,
                                input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                input logic mv, input logic [4:0] mr, input logic [31:0] md,
                                input logic expAr, input logic expMr, input logic pushOk);
      exp_t e;
      ctrl_reset = rst;
      alu_valid  = av;
      alu_reg    = ar;
      alu_data   = ad;
      md_valid   = mv;
      md_reg     = mr;
      md_data    = md;
      @(negedge clock);
      checkOutput("alu_ready", {31'b0, alu_ready}, {31'b0, expAr});
      checkOutput("md_ready", {31'b0, md_ready}, {31'b0, expMr});
      if (pushOk && expAr && ar != 5'd0) begin
         e.r = ar; e.d = ad; e.cyc = cyc + 1;
         sb.push_back(e);
      end
      if (pushOk && expMr && mr != 5'd0) begin
         e.r = mr; e.d = md; e.cyc = cyc + 1;
         sb.push_back(e);
      end
      @(posedge clock);
      #1;
   endtask

   // Two reset cycles with both requesters valid: nothing may be granted.
   task automatic resetDut();
      applyStimulus(1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      ctrl_reset = 1'b1;
      alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
      md_valid = 1'b0; md_reg = '0; md_data = '0;
      @(posedge clock);
      #1;

      // Reset then idle.
      resetDut();
      idle(5);
      checkOutput("reset_conflict_cnt", {16'b0, conflict_cnt}, 32'd0);
      checkOutput("reset_writeReg", {27'b0, ctrl_writeReg}, 32'd0);
      checkOutput("reset_data", data_writeReg, 32'd0);

      // ALU only.
      applyStimulus(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1);
      checkOutput("alu_byp_valid", {31'b0, byp_valid}, 32'd1);
      checkOutput("alu_byp_reg", {27'b0, byp_reg}, 32'd5);
      checkOutput("alu_byp_data", byp_data, 32'hDEADBEEF);
      idle(2);
      checkOutput("hold_writeReg", {27'b0, ctrl_writeReg}, 32'd5);
      checkOutput("hold_data", data_writeReg, 32'hDEADBEEF);
      checkOutput("rf_r5", rf[5], 32'hDEADBEEF);

      // Both valid, each drops after its ready.
      resetDut();
      applyStimulus(1'b0, 1'b1, 5'd3, 32'd1, 1'b1, 5'd7, 32'd2, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 5'd3, 32'd1, 1'b1, 5'd7, 32'd2, 1'b0, 1'b1, 1'b1);
      idle(2);
      checkOutput("pair_conflict_cnt", {16'b0, conflict_cnt}, 32'd1);
      checkOutput("rf_r3", rf[3], 32'd1);
      checkOutput("rf_r7", rf[7], 32'd2);

      // Both continuously valid: grants alternate.
      resetDut();
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b0, 1'b1, 5'(i + 1), 32'hA000 + 32'(i), 1'b1, 5'(i + 10), 32'hB000 + 32'(i),
                       (i % 2) == 0, (i % 2) == 1, 1'b1);
      idle(2);
      checkOutput("alt_conflict_cnt", {16'b0, conflict_cnt}, 32'd6);

      // MD write to r0 is consumed but never committed.
      resetDut();
      applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b1, 1'b1);
      checkOutput("r0_writeEnable", {31'b0, ctrl_writeEnable}, 32'd0);
      idle(2);
      checkOutput("rf_r0", rf[0], 32'd0);

      // ALU accepted, then reset the next cycle: the write is discarded.
      resetDut();
      applyStimulus(1'b0, 1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
      checkOutput("rf_r9", rf[9], 32'd0);
      applyStimulus(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66, 1'b0, 1'b1, 1'b1);
      idle(3);

      checkOutput("scoreboard_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
